// File: rtl/imm_pkg.sv
// Shared types for the ARM immediate-extension stage: mode codes, result bundle, widths.
package imm_pkg;

    localparam int INST_W    = 24;
    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        IMM_DP_ROT = 3'd0,
        IMM_12     = 3'd1,
        IMM_BR     = 3'd2,
        IMM_HALF   = 3'd3
    } imm_src_e;

    // ext_imm is carried at the widest legal output width; the stage keeps the low DATA_W bits.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] ext_imm;
        logic                 shift_c;
        logic                 illegal;
    } imm_result_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: decodes the mode and produces the extended
// immediate, the shifter carry-out and the illegal-mode flag.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int SRC_W = 3
) (
    input  logic [INST_W-1:0] inst_i,
    input  logic [SRC_W-1:0]  imm_src_i,
    input  logic              c_in_i,
    output imm_result_t       result_o
);

    logic [4:0]  rot_amt;
    logic [63:0] rot_pair;
    logic [31:0] rot_val;

    // Shifting a doubled copy right yields a rotate-right in the low word.
    assign rot_amt  = {inst_i[11:8], 1'b0};
    assign rot_pair = {24'b0, inst_i[7:0], 24'b0, inst_i[7:0]} >> rot_amt;
    assign rot_val  = rot_pair[31:0];

    always_comb begin
        result_o         = '0;
        result_o.shift_c = c_in_i;
        if (imm_src_i >= SRC_W'(4)) begin
            result_o.illegal = 1'b1;
        end else begin
            case (imm_src_e'(imm_src_i[2:0]))
                IMM_DP_ROT: begin
                    result_o.ext_imm = {32'b0, rot_val};
                    if (inst_i[11:8] != 4'd0) begin
                        result_o.shift_c = rot_val[31];
                    end
                end
                IMM_12:   result_o.ext_imm = {52'b0, inst_i[11:0]};
                IMM_BR:   result_o.ext_imm = {{38{inst_i[23]}}, inst_i, 2'b00};
                IMM_HALF: result_o.ext_imm = {56'b0, inst_i[11:8], inst_i[3:0]};
                default:  result_o.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Elastic registered immediate-extension stage: output register plus one-entry skid
// buffer around imm_extend_core, valid/ready on both sides.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SRC_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    input  logic [SRC_W-1:0]  imm_src,
    input  logic              c_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic              shift_c,
    output logic              illegal
);

    localparam int ENT_W = DATA_W + 2;

    imm_result_t      core_res;
    logic [ENT_W-1:0] in_ent;
    logic             accept;

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [ENT_W-1:0] out_ent_q, out_ent_d;
    logic [ENT_W-1:0] skid_ent_q, skid_ent_d;

    imm_extend_core #(.SRC_W(SRC_W)) u_core (
        .inst_i    (inst),
        .imm_src_i (imm_src),
        .c_in_i    (c_in),
        .result_o  (core_res)
    );

    assign in_ent = {core_res.ext_imm[DATA_W-1:0], core_res.shift_c, core_res.illegal};

    if (DATA_W < IMM_MAX_W) begin : g_trim
        logic unused_hi;
        assign unused_hi = ^core_res.ext_imm[IMM_MAX_W-1:DATA_W];
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid & ~skid_valid_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_ent_d    = out_ent_q;
        skid_ent_d   = skid_ent_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // A full skid blocks the input, so it always refills the output first.
            if (skid_valid_q) begin
                out_ent_d    = skid_ent_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_ent_d   = in_ent;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_ent_d   = in_ent;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_ent_q    <= '0;
            skid_ent_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_ent_q    <= out_ent_d;
            skid_ent_q   <= skid_ent_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ext_imm   = out_ent_q[ENT_W-1:2];
    assign shift_c   = out_ent_q[1];
    assign illegal   = out_ent_q[0];

endmodule
